// File: rtl/vn_accumulator_if.sv
// Handshake bundle between the variable-node accumulator and its neighbours:
// LLR and message inputs, extrinsic output stream, posterior/decision status.
interface vn_accumulator_if #(
   parameter int W = 6
);
   logic signed [W-1:0] llr_in;
   logic                llr_valid;
   logic                llr_ready;
   logic signed [W-1:0] msg_in;
   logic                msg_valid;
   logic                msg_ready;
   logic signed [W-1:0] ext_out;
   logic [2:0]          ext_idx;
   logic                ext_valid;
   logic                ext_ready;
   logic signed [W-1:0] post_out;
   logic                hard_bit;
   logic                busy;

   modport master (
      output llr_in, llr_valid, msg_in, msg_valid, ext_ready,
      input  llr_ready, msg_ready, ext_out, ext_idx, ext_valid,
             post_out, hard_bit, busy
   );

   modport slave (
      input  llr_in, llr_valid, msg_in, msg_valid, ext_ready,
      output llr_ready, msg_ready, ext_out, ext_idx, ext_valid,
             post_out, hard_bit, busy
   );
endinterface

// File: rtl/vn_accumulator.sv
// LDPC variable-node update: sums one channel LLR with DEGREE check messages,
// then streams the DEGREE extrinsic messages and holds posterior/hard decision.
module vn_accumulator #(
   parameter int W      = 6,
   parameter int DEGREE = 3,
   parameter int AW     = W + 4
) (
   input  logic              clk,
   input  logic              rst,
   vn_accumulator_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

   localparam logic [2:0]          LAST   = 3'(DEGREE - 1);
   localparam logic signed [AW-1:0] SAT_HI = AW'((1 <<< (W - 1)) - 1);
   localparam logic signed [AW-1:0] SAT_LO = -SAT_HI;

   function automatic logic signed [AW-1:0] sext(input logic signed [W-1:0] v);
      return {{(AW - W){v[W-1]}}, v};
   endfunction

   // The most negative code has no positive twin, so it is folded to -(2^(W-1)-1).
   function automatic logic signed [W-1:0] clamp_in(input logic signed [W-1:0] v);
      if (v == {1'b1, {(W - 1){1'b0}}})
         return {1'b1, {(W - 2){1'b0}}, 1'b1};
      return v;
   endfunction

   function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] v);
      if (v > SAT_HI) return SAT_HI[W-1:0];
      if (v < SAT_LO) return SAT_LO[W-1:0];
      return v[W-1:0];
   endfunction

   state_t              state, state_nxt;
   logic signed [AW-1:0] acc;
   logic [2:0]          cnt, idx;
   logic signed [W-1:0] store [8];
   logic signed [W-1:0] ext_out_r, post_out_r;
   logic [2:0]          ext_idx_r;
   logic                ext_valid_r, hard_bit_r;
   logic                llr_ready_c, msg_ready_c;
   logic                llr_take, msg_take, ext_take, last_msg, last_ext;
   logic signed [W-1:0] llr_cl, msg_cl, first_store;
   logic signed [AW-1:0] acc_sum, first_diff, next_diff;
   logic [2:0]          idx_inc;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      llr_ready_c = 1'b0;
      msg_ready_c = 1'b0;
      case (state)
         IDLE: begin
            llr_ready_c = 1'b1;
            if (bus.llr_valid) state_nxt = ACCUM;
         end
         ACCUM: begin
            msg_ready_c = 1'b1;
            if (bus.msg_valid && cnt == LAST) state_nxt = EMIT;
         end
         EMIT: begin
            if (ext_valid_r && bus.ext_ready && idx == LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign llr_take = llr_ready_c & bus.llr_valid;
   assign msg_take = msg_ready_c & bus.msg_valid;
   assign ext_take = ext_valid_r & bus.ext_ready;
   assign last_msg = (cnt == LAST);
   assign last_ext = (idx == LAST);
   assign llr_cl   = clamp_in(bus.llr_in);
   assign msg_cl   = clamp_in(bus.msg_in);
   assign acc_sum  = acc + sext(msg_cl);
   assign idx_inc  = idx + 3'd1;

   // With DEGREE=1 the message for slot 0 is still on the input when the first extrinsic is formed.
   assign first_store = (cnt == 3'd0) ? msg_cl : store[0];
   assign first_diff  = acc_sum - sext(first_store);
   assign next_diff   = acc - sext(store[idx_inc]);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         idx         <= '0;
         ext_out_r   <= '0;
         ext_idx_r   <= '0;
         ext_valid_r <= 1'b0;
         post_out_r  <= '0;
         hard_bit_r  <= 1'b0;
         for (int i = 0; i < 8; i++) store[i] <= '0;
      end else begin
         if (llr_take) begin
            acc <= sext(llr_cl);
            cnt <= '0;
         end
         if (msg_take) begin
            store[cnt] <= msg_cl;
            acc        <= acc_sum;
            cnt        <= cnt + 3'd1;
            if (last_msg) begin
               post_out_r  <= sat(acc_sum);
               hard_bit_r  <= acc_sum[AW-1];
               idx         <= '0;
               ext_idx_r   <= '0;
               ext_out_r   <= sat(first_diff);
               ext_valid_r <= 1'b1;
            end
         end
         if (ext_take) begin
            if (last_ext) begin
               ext_valid_r <= 1'b0;
            end else begin
               idx       <= idx_inc;
               ext_idx_r <= idx_inc;
               ext_out_r <= sat(next_diff);
            end
         end
      end
   end

   assign bus.llr_ready = llr_ready_c;
   assign bus.msg_ready = msg_ready_c;
   assign bus.ext_out   = ext_out_r;
   assign bus.ext_idx   = ext_idx_r;
   assign bus.ext_valid = ext_valid_r;
   assign bus.post_out  = post_out_r;
   assign bus.hard_bit  = hard_bit_r;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_vn_accumulator.sv
// Directed table-driven bench for vn_accumulator: full update sequences,
// saturation, backpressure, ignored valids and mid-operation reset.
module tb_vn_accumulator;
   localparam int W      = 6;
   localparam int DEGREE = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vn_accumulator_if #(.W(W)) bus ();

   vn_accumulator #(.W(W), .DEGREE(DEGREE), .AW(W + 4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int llr;
      int m0, m1, m2;
      int stall_idx;
      int stall_n;
      int glitch;
      int post;
      int hard;
      int e0, e1, e2;
   } vec_t;

   vec_t vecs [5];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(int llr, int m0, int m1, int m2, int post, int hard,
                               int e0, int e1, int e2, int stall_idx, int stall_n, int glitch);
      vec_t v;
      v.llr = llr; v.m0 = m0; v.m1 = m1; v.m2 = m2;
      v.post = post; v.hard = hard;
      v.e0 = e0; v.e1 = e1; v.e2 = e2;
      v.stall_idx = stall_idx; v.stall_n = stall_n; v.glitch = glitch;
      return v;
   endfunction

   function automatic int pick(int k, int a, int b, int c);
      if (k == 0) return a;
      if (k == 1) return b;
      return c;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic send(input bit is_llr, input int val, input int glitch);
      int n;
      n = 0;
      if (is_llr) begin
         bus.llr_in    = W'(val);
         bus.llr_valid = 1'b1;
      end else begin
         bus.msg_in    = W'(val);
         bus.msg_valid = 1'b1;
         if (glitch != 0) begin
            bus.llr_in    = W'(20);
            bus.llr_valid = 1'b1;
         end
      end
      while (!(is_llr ? bus.llr_ready : bus.msg_ready) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (is_llr) chk("llr_ready_wait", int'(bus.llr_ready), 1);
      else        chk("msg_ready_wait", int'(bus.msg_ready), 1);
      if (glitch != 0) chk("llr_ready_in_accum", int'(bus.llr_ready), 0);
      @(posedge clk); #1;
      bus.llr_valid = 1'b0;
      bus.msg_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int e;
      bus.ext_ready = 1'b1;
      send(1'b1, v.llr, 0);
      send(1'b0, v.m0, v.glitch);
      send(1'b0, v.m1, v.glitch);
      send(1'b0, v.m2, v.glitch);
      chk("first_ext_latency", int'(bus.ext_valid), 1);
      chk("post_out", int'(bus.post_out), v.post);
      chk("hard_bit", int'(bus.hard_bit), v.hard);
      for (int k = 0; k < DEGREE; k++) begin
         e = pick(k, v.e0, v.e1, v.e2);
         if (k == v.stall_idx) begin
            bus.ext_ready = 1'b0;
            for (int s = 0; s < v.stall_n; s++) begin
               @(posedge clk); #1;
               chk("stall_ext_valid", int'(bus.ext_valid), 1);
               chk("stall_ext_out", int'(bus.ext_out), e);
               chk("stall_ext_idx", int'(bus.ext_idx), k);
               chk("stall_llr_ready", int'(bus.llr_ready), 0);
               chk("stall_msg_ready", int'(bus.msg_ready), 0);
            end
            bus.ext_ready = 1'b1;
         end
         chk("ext_valid", int'(bus.ext_valid), 1);
         chk("ext_idx", int'(bus.ext_idx), k);
         chk("ext_out", int'(bus.ext_out), e);
         chk("emit_llr_ready", int'(bus.llr_ready), 0);
         chk("emit_msg_ready", int'(bus.msg_ready), 0);
         @(posedge clk); #1;
      end
      chk("ext_valid_done", int'(bus.ext_valid), 0);
      chk("idle_llr_ready", int'(bus.llr_ready), 1);
      chk("idle_busy", int'(bus.busy), 0);
      chk("post_held", int'(bus.post_out), v.post);
      chk("hard_held", int'(bus.hard_bit), v.hard);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.llr_in    = '0;
      bus.llr_valid = 1'b0;
      bus.msg_in    = '0;
      bus.msg_valid = 1'b0;
      bus.ext_ready = 1'b1;

      //          llr  m0   m1   m2  post hard  e0   e1   e2  stall  n  glitch
      vecs[0] = mk( 10,   5,  -3,   7,  19, 0,  14,  22,  12,   -1,   0, 0);
      vecs[1] = mk( 31,  31,  31,  31,  31, 0,  31,  31,  31,   -1,   0, 0);
      vecs[2] = mk(-32, -20, -20,   5, -31, 1, -31, -31, -31,   -1,   0, 0);
      vecs[3] = mk(  3,  -1,  -1,  -1,   0, 0,   1,   1,   1,   -1,   0, 1);
      vecs[4] = mk( 10,   5,  -3,   7,  19, 0,  14,  22,  12,    1,   3, 0);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_llr_ready", int'(bus.llr_ready), 1);
      chk("rst_msg_ready", int'(bus.msg_ready), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_ext_valid", int'(bus.ext_valid), 0);
      chk("rst_ext_out", int'(bus.ext_out), 0);
      chk("rst_ext_idx", int'(bus.ext_idx), 0);
      chk("rst_post_out", int'(bus.post_out), 0);
      chk("rst_hard_bit", int'(bus.hard_bit), 0);

      // A message offered while idle must not start anything.
      bus.msg_in    = W'(9);
      bus.msg_valid = 1'b1;
      chk("idle_msg_ready", int'(bus.msg_ready), 0);
      @(posedge clk); #1;
      bus.msg_valid = 1'b0;
      chk("idle_msg_ignored", int'(bus.busy), 0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Abort mid-accumulation, then check the next update is clean.
      send(1'b1, 10, 0);
      send(1'b0, 5, 0);
      send(1'b0, -3, 0);
      chk("pre_abort_busy", int'(bus.busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_ext_valid", int'(bus.ext_valid), 0);
      chk("abort_post_out", int'(bus.post_out), 0);
      chk("abort_hard_bit", int'(bus.hard_bit), 0);
      chk("abort_llr_ready", int'(bus.llr_ready), 1);
      chk("abort_msg_ready", int'(bus.msg_ready), 0);
      run_vec(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
